// File: rtl/io_bridge.sv
// I/O handshake stage between the core and the board switches, key and 7-segment displays.
// Debounces the key, captures switch words, and renders printed values as signed decimal.
module io_bridge #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter bit BLANK_ZEROS     = 1'b1
) (
  input  logic        Clock,
  input  logic        reset,
  input  logic        halt,
  input  logic        input_flag,
  input  logic        output_flag,
  input  logic [31:0] data_in,
  input  logic [14:0] SW,
  input  logic        insert,
  output logic [31:0] user_input,
  output logic        stall,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5,
  output logic [6:0]  HEX6,
  output logic [6:0]  HEX7
);

  typedef enum logic [1:0] {IDLE, IN_WAIT, CONV, DONE} state_t;

  localparam logic [7:0] DB_LAST   = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  state_t      state_reg, state_next;
  logic        sync1_reg, sync2_reg;
  logic [7:0]  db_cnt_reg;
  logic        db_level_reg, db_prev_reg;
  logic        press;
  logic [31:0] data_reg, mag_reg, bcd_reg, user_input_reg;
  logic        neg_reg, ovf_reg;
  logic [5:0]  step_reg;
  logic [6:0]  hex_reg  [8];
  logic [6:0]  hex_next [8];
  logic [31:0] bcd_adj, bcd_next, mag_next, abs_val;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  // Key path: two-flop synchronizer, then a counter that must see a steady new level.
  always_ff @(posedge Clock) begin
    if (reset) begin
      sync1_reg    <= 1'b0;
      sync2_reg    <= 1'b0;
      db_cnt_reg   <= '0;
      db_level_reg <= 1'b0;
      db_prev_reg  <= 1'b0;
    end else begin
      sync1_reg   <= insert;
      sync2_reg   <= sync1_reg;
      db_prev_reg <= db_level_reg;
      if (sync2_reg != db_level_reg) begin
        if (db_cnt_reg == DB_LAST) begin
          db_level_reg <= sync2_reg;
          db_cnt_reg   <= '0;
        end else begin
          db_cnt_reg <= db_cnt_reg + 8'd1;
        end
      end else begin
        db_cnt_reg <= '0;
      end
    end
  end

  assign press = db_level_reg & ~db_prev_reg;

  always_comb begin
    state_next = state_reg;
    stall      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!halt) begin
          if (input_flag) begin
            stall      = 1'b1;
            state_next = IN_WAIT;
          end else if (output_flag) begin
            stall      = 1'b1;
            state_next = CONV;
          end
        end
      end
      IN_WAIT: begin
        stall = 1'b1;
        if (press) state_next = DONE;
      end
      CONV: begin
        stall = 1'b1;
        if (step_reg == 6'd32) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // One double-dabble iteration: add 3 to any nibble >= 5, then shift the pair left.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                  bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
    end
  endgenerate

  assign bcd_next = {bcd_adj[30:0], mag_reg[31]};
  assign mag_next = {mag_reg[30:0], 1'b0};
  assign abs_val  = data_reg[31] ? (~data_reg + 32'd1) : data_reg;

  // Digit rendering from the final iteration's result; sign and overflow override digits.
  generate
    for (gi = 0; gi < 8; gi++) begin : g_seg
      logic lead_zero;
      assign lead_zero = (bcd_next[31:gi*4] == '0);
      if (gi == 7) begin : g_top
        assign hex_next[gi] = (ovf_reg || neg_reg) ? SEG_DASH :
                              (BLANK_ZEROS && lead_zero) ? SEG_BLANK :
                              seg7(bcd_next[gi*4 +: 4]);
      end else if (gi == 0) begin : g_low
        assign hex_next[gi] = ovf_reg ? SEG_DASH : seg7(bcd_next[gi*4 +: 4]);
      end else begin : g_mid
        assign hex_next[gi] = ovf_reg ? SEG_DASH :
                              (BLANK_ZEROS && lead_zero) ? SEG_BLANK :
                              seg7(bcd_next[gi*4 +: 4]);
      end
    end
  endgenerate

  always_ff @(posedge Clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      data_reg       <= '0;
      mag_reg        <= '0;
      bcd_reg        <= '0;
      neg_reg        <= 1'b0;
      ovf_reg        <= 1'b0;
      step_reg       <= '0;
      user_input_reg <= '0;
      for (int i = 0; i < 8; i++) hex_reg[i] <= SEG_BLANK;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          step_reg <= '0;
          if (!halt && !input_flag && output_flag) data_reg <= data_in;
        end
        IN_WAIT: begin
          if (press) user_input_reg <= {{17{SW[14]}}, SW};
        end
        CONV: begin
          step_reg <= step_reg + 6'd1;
          if (step_reg == 6'd0) begin
            neg_reg <= data_reg[31];
            mag_reg <= abs_val;
            bcd_reg <= '0;
            ovf_reg <= data_reg[31] ? (abs_val > 32'd9999999) : (abs_val > 32'd99999999);
          end else begin
            mag_reg <= mag_next;
            bcd_reg <= bcd_next;
            if (step_reg == 6'd32) begin
              for (int i = 0; i < 8; i++) hex_reg[i] <= hex_next[i];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign user_input = user_input_reg;
  assign HEX0 = hex_reg[0];
  assign HEX1 = hex_reg[1];
  assign HEX2 = hex_reg[2];
  assign HEX3 = hex_reg[3];
  assign HEX4 = hex_reg[4];
  assign HEX5 = hex_reg[5];
  assign HEX6 = hex_reg[6];
  assign HEX7 = hex_reg[7];

endmodule

// File: doc/io_bridge.md
Name: io_bridge

Overview:
Handshaking I/O stage between the single-cycle core and the board switches, key and 7-segment displays.
- Consumes the core's input_flag/output_flag and the register value to print.
- Produces the user_input word and a stall that freezes the PC until the I/O operation completes.
- Converts printed values to signed decimal with a sequential double-dabble engine and holds them on HEX0..HEX7.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive equal synchronized samples of insert needed to change the debounced level (range 1..255)
BLANK_ZEROS, 1, 1 = suppress leading zeros (HEX0 always shown); 0 = show all digits

Ports:
Clock  in  1  core clock; all state on rising edge
reset  in  1  synchronous, active-high
halt  in  1  core halted; new I/O requests ignored
input_flag  in  1  current instruction is an input instruction
output_flag  in  1  current instruction is an output instruction
data_in  in  32  two's-complement value to display (core ReadData1)
SW  in  15  switch value to read
insert  in  1  key level, 1 = pressed (asynchronous)
user_input  out  32  latched input word for register writeback
stall  out  1  1 = hold PC this cycle
HEX0..HEX7  out  7 each  active-low segments {g,f,e,d,c,b,a}; HEX0 = least significant digit

Behaviour:
- Reset values:
  - state IDLE; user_input 0; stall 0.
  - All HEX = 7'h7F (blank).
  - Sync flops, debounce counter and debounced level = 0.
- insert path:
  - 2-flop synchronizer, then debounce counter.
  - The debounced level flips after DEBOUNCE_CYCLES consecutive samples differing from it.
  - press = rising edge of the debounced level, one cycle wide.
- FSM states: IDLE, IN_WAIT, CONV, DONE.
- stall is combinational: 1 when state = IN_WAIT, or state = CONV, or (state = IDLE and halt = 0 and either flag = 1); otherwise 0.
- IDLE transitions:
  - halt = 1: stay; flags ignored.
  - input_flag = 1: go to IN_WAIT. input_flag has priority if both flags are set.
  - output_flag = 1: latch data_in; go to CONV.
- IN_WAIT:
  - press: user_input <= sign-extended SW ({17{SW[14]}}, SW); go to DONE.
  - press outside IN_WAIT is discarded; a held key must be released and pressed again.
- CONV:
  - Load magnitude = |data_in|, neg = data_in[31].
  - 32 shift-add-3 iterations, one per cycle, into 8 BCD nibbles.
  - Load is 1 cycle, so CONV lasts 33 cycles. Then commit to HEX and go to DONE.
  - Latency: output_flag sampled in cycle 0 → HEX updated at the edge ending cycle 33; stall high for cycles 0..33.
- DONE:
  - stall = 0 for exactly one cycle so the PC advances.
  - Next state is IDLE unconditionally; flags are not sampled in DONE.
- Display encoding:
  - Non-negative: 8 digits 0..99,999,999.
  - Negative: HEX7 = '-' (7'h3F), magnitude in HEX6..HEX0, max 9,999,999.
  - Overflow (non-negative > 99,999,999, negative magnitude > 9,999,999, or 32'h80000000): all 8 digits '-'.
  - Leading-zero blanking (BLANK_ZEROS = 1) applies to magnitude digits only; the '-' sign stays at HEX7.
- HEX and user_input hold their values until the next commit, including across halt.
- reset mid-operation (any state) returns to reset values on the next edge. An in-flight conversion is discarded and the displays blank.
- halt rising while in IN_WAIT/CONV does not abort; the operation completes through DONE.

Test Plan:
- Reset, then output_flag=1 with data_in=1234 held → stall=1 for 34 cycles, then stall=0 for 1 cycle; HEX3..HEX0 = 1,2,3,4 (7'h79,7'h24,7'h30,7'h19); HEX7..HEX4 = 7'h7F.
- data_in=-5 (32'hFFFFFFFB) → HEX7=7'h3F, HEX0=7'h12, others blank; data_in=0 → HEX0=7'h40, others blank.
- data_in=100000000 and data_in=32'h80000000 → all HEX = 7'h3F.
- input_flag=1, SW=15'h4001, insert bouncing 1-0-1 every cycle for 6 cycles, then stable 1 → no capture during bounce; capture DEBOUNCE_CYCLES+2 cycles after stable; user_input=32'hFFFFC001; stall drops for exactly 1 cycle.
- insert held 1 before input_flag rises → no capture until release and re-press; halt=1 with output_flag=1 in IDLE → stall=0, HEX unchanged.
- reset asserted at cycle 10 of CONV → next cycle state IDLE, stall=0, all HEX=7'h7F, user_input=0.
